// File: rtl/rvsp_pkg.sv
// rvsp_pkg: shared encodings for the multi-cycle RV32I-subset core
package rvsp_pkg;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BNE = 3'b001;
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_e;
  typedef enum logic [1:0] {RD_ALU, RD_MDR, RD_LINK} rd_src_e;
endpackage

// File: rtl/unid_controle_mc.sv
// unid_controle_mc: multi-cycle FSM and instruction decode driving the datapath enables
module unid_controle_mc
  import rvsp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_ack_i,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       eq_i,
  output state_e     state_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_alu_o,
  output logic       ir_we_o,
  output logic       ab_we_o,
  output logic       pc_we_o,
  output logic       pc_tgt_o,
  output alu_op_e    alu_op_o,
  output logic       alu_imm_o,
  output logic       alu_we_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output rd_src_e    rd_src_o,
  output imm_e       imm_sel_o
);
  state_e state_q, state_d;
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, legal, taken;
  always_comb begin
    is_r = opcode_i == OP_R;
    is_i = opcode_i == OP_I;
    is_lw = opcode_i == OP_LW;
    is_sw = opcode_i == OP_SW;
    is_br = opcode_i == OP_BR;
    is_jal = opcode_i == OP_JAL;
    legal = is_r | is_i | is_lw | is_sw | is_br | is_jal;
    taken = eq_i ^ (funct3_i == F3_BNE);
    alu_op_o = !is_r ? ALU_ADD
             : funct3_i == F3_SLT ? ALU_SLT
             : funct3_i == F3_OR ? ALU_OR
             : funct3_i == F3_AND ? ALU_AND
             : funct7b5_i ? ALU_SUB : ALU_ADD;
    alu_imm_o = !is_r;
    imm_sel_o = is_sw ? IMM_S : is_br ? IMM_B : is_jal ? IMM_J : IMM_I;
    rd_src_o = is_jal ? RD_LINK : is_lw ? RD_MDR : RD_ALU;
  end
  // mem_req is gated by rst_n so the port stays idle while reset is held
  always_comb begin
    state_d = state_q;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    addr_alu_o = 1'b0;
    ir_we_o = 1'b0;
    ab_we_o = 1'b0;
    pc_we_o = 1'b0;
    pc_tgt_o = 1'b0;
    alu_we_o = 1'b0;
    mdr_we_o = 1'b0;
    rf_we_o = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_o = rst_n;
        ir_we_o = mem_ack_i;
        pc_we_o = mem_ack_i;
        state_d = mem_ack_i ? DECODE : FETCH;
      end
      DECODE: begin
        ab_we_o = 1'b1;
        state_d = legal ? EXEC : HALT;
      end
      EXEC: begin
        alu_we_o = is_r | is_i | is_lw | is_sw;
        pc_we_o = is_jal | (is_br & taken);
        pc_tgt_o = 1'b1;
        rf_we_o = is_jal;
        state_d = (is_r | is_i) ? WB : (is_lw | is_sw) ? MEM : FETCH;
      end
      MEM: begin
        mem_req_o = rst_n;
        mem_we_o = rst_n & is_sw;
        addr_alu_o = 1'b1;
        mdr_we_o = mem_ack_i & is_lw;
        state_d = !mem_ack_i ? MEM : is_lw ? WB : FETCH;
      end
      WB: begin
        rf_we_o = 1'b1;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  end
  assign state_o = state_q;
endmodule

// File: rtl/datapath_multiciclo.sv
// datapath_multiciclo: multi-cycle RV32I-subset core sharing one req/ack memory port
module datapath_multiciclo
  import rvsp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MEM_ADDR_W = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_ack,
  output logic [XLEN-1:0]       pc,
  output logic [2:0]            estado,
  output logic                  halt
);
  state_e state;
  alu_op_e alu_op;
  imm_e imm_sel;
  rd_src_e rd_src;
  logic addr_alu, ir_we, ab_we, pc_we, pc_tgt, alu_imm, alu_we, mdr_we, rf_we;
  logic [31:0] ir_q;
  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, a_q, b_q, alu_q, mdr_q;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] imm, opb, alu_y, rd_val, mem_baddr;
  logic signed [31:0] imm32;
  unid_controle_mc u_ctrl (
    .clk(clk), .rst_n(rst_n), .mem_ack_i(mem_ack),
    .opcode_i(ir_q[6:0]), .funct3_i(ir_q[14:12]), .funct7b5_i(ir_q[30]), .eq_i(a_q == b_q),
    .state_o(state), .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_alu_o(addr_alu),
    .ir_we_o(ir_we), .ab_we_o(ab_we), .pc_we_o(pc_we), .pc_tgt_o(pc_tgt),
    .alu_op_o(alu_op), .alu_imm_o(alu_imm), .alu_we_o(alu_we), .mdr_we_o(mdr_we),
    .rf_we_o(rf_we), .rd_src_o(rd_src), .imm_sel_o(imm_sel)
  );
  // immediates are built at 32 bits and then sign-extended or truncated to XLEN
  always_comb begin
    imm32 = imm_sel == IMM_S ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]}
          : imm_sel == IMM_B ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}
          : imm_sel == IMM_J ? {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}
          : {{20{ir_q[31]}}, ir_q[31:20]};
    imm = XLEN'(imm32);
    opb = alu_imm ? imm : b_q;
    alu_y = alu_op == ALU_SUB ? a_q - opb
          : alu_op == ALU_AND ? a_q & opb
          : alu_op == ALU_OR ? a_q | opb
          : alu_op == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(opb)}
          : a_q + opb;
    pc_d = pc_tgt ? oldpc_q + imm : pc_q + XLEN'(4);
    rd_val = rd_src == RD_MDR ? mdr_q : rd_src == RD_LINK ? oldpc_q + XLEN'(4) : alu_q;
    mem_baddr = addr_alu ? alu_q : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      oldpc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (ir_we) begin
        ir_q <= 32'(mem_rdata);
        oldpc_q <= pc_q;
      end
      if (pc_we) pc_q <= pc_d;
      if (ab_we) begin
        a_q <= rf_q[ir_q[19:15]];
        b_q <= rf_q[ir_q[24:20]];
      end
      if (alu_we) alu_q <= alu_y;
      if (mdr_we) mdr_q <= mem_rdata;
      if (rf_we && ir_q[11:7] != 5'd0) rf_q[ir_q[11:7]] <= rd_val;
    end
  end
  assign mem_addr = MEM_ADDR_W'(mem_baddr >> 2);
  assign mem_wdata = b_q;
  assign pc = pc_q;
  assign estado = state;
  assign halt = state == HALT;
endmodule
